ssd_page_scheduler: RTL

- Shares the single 4-digit seven-segment display between NUM_SRC 16-bit debug sources, such as PC, instruction, ALU result and register value.
- Selects one source ("page") at a time. A debounced push-button steps pages; an optional auto-rotate mode steps them on a dwell timer.
- On each page change, briefly shows a page banner first.
- Output disp_num drives the existing ssd display multiplexer's 16-bit input.

---
 rtl/ssd_pkg.sv | 22 ++
 rtl/btn_debouncer.sv | 44 ++++
 rtl/ssd_page_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment page scheduler.
package ssd_pkg;

  typedef enum logic {
    BANNER = 1'b0,
    SHOW   = 1'b1
  } state_t;

  localparam logic [3:0]  BANNER_PREFIX = 4'hA;
  localparam logic [15:0] EMPTY_VALUE   = 16'h0000;

  // Counter width for a terminal count n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // (a + b) mod n for a, b < n, without a divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? (a + b - n) : (a + b);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// Latency: stable raw press to pulse is DEBOUNCE_CYCLES+3 cycles; no backpressure.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);
  import ssd_pkg::*;

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);

  logic          sync1, sync2, level_d;
  logic [CW-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_page_scheduler.sv
// Pages NUM_SRC 16-bit debug sources onto the shared display, with a banner per page change.
// Latency: disp_num/banner_on combinational from registered page/state; button adds DEBOUNCE_CYCLES+3.
// No backpressure; `define SSD_PAGE_SNAPSHOT_EN freezes the shown value while a page is displayed.
module ssd_page_scheduler import ssd_pkg::*; #(
  parameter int NUM_SRC         = 4,
  parameter int DWELL_CYCLES    = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BANNER_CYCLES   = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC*16-1:0] src_bus,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic                  btn_next,
  input  logic                  auto_en,
  output logic [15:0]           disp_num,
  output logic [3:0]            page,
  output logic                  banner_on
);

  localparam int PW = cnt_w(NUM_SRC);
  localparam int DW = cnt_w(DWELL_CYCLES);
  localparam int BW = cnt_w(BANNER_CYCLES);

  state_t          state, state_n;
  logic [PW-1:0]   page_r, page_n, next_pg;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic [15:0]     src_arr [NUM_SRC];
  logic [15:0]     show_val;
  logic            btn_pulse, btn_level_unused;
  logic            any_valid, dwell_hit, evict;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_arr[g] = src_bus[16*g +: 16];
  end

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_next),
    .level (btn_level_unused),
    .pulse (btn_pulse)
  );

  // Scan downward so the nearest valid page after the current one wins.
  always_comb begin
    next_pg = page_r;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      if (src_valid[PW'(wrap_add(int'(page_r), k, NUM_SRC))])
        next_pg = PW'(wrap_add(int'(page_r), k, NUM_SRC));
    end
  end

  assign any_valid = |src_valid;
  assign dwell_hit = auto_en && (dcnt == DW'(DWELL_CYCLES - 1));
  assign evict     = !src_valid[page_r];

  always_comb begin
    state_n = state;
    page_n  = page_r;
    dcnt_n  = dcnt;
    bcnt_n  = bcnt;
    if (!any_valid) begin
      state_n = SHOW;
      dcnt_n  = '0;
      bcnt_n  = '0;
    end else begin
      case (state)
        BANNER: begin
          if (btn_pulse) begin
            page_n = next_pg;
            bcnt_n = '0;
          end else if (bcnt == BW'(BANNER_CYCLES - 1)) begin
            state_n = SHOW;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
        SHOW: begin
          if (btn_pulse || dwell_hit || evict) begin
            page_n  = next_pg;
            state_n = BANNER;
            dcnt_n  = '0;
            bcnt_n  = '0;
          end else if (auto_en) begin
            dcnt_n = dcnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BANNER;
      page_r <= '0;
      dcnt   <= '0;
      bcnt   <= '0;
    end else begin
      state  <= state_n;
      page_r <= page_n;
      dcnt   <= dcnt_n;
      bcnt   <= bcnt_n;
    end
  end

`ifdef SSD_PAGE_SNAPSHOT_EN
  logic [15:0] snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      snap <= EMPTY_VALUE;
    else if (state_n == SHOW && state != SHOW)
      snap <= src_arr[page_n];
  end

  assign show_val = snap;
`else
  assign show_val = src_arr[page_r];
`endif

  assign page = 4'(page_r);

  always_comb begin
    disp_num  = show_val;
    banner_on = 1'b0;
    if (state == BANNER) begin
      disp_num  = {BANNER_PREFIX, 8'h00, page};
      banner_on = 1'b1;
    end else if (!any_valid) begin
      disp_num = EMPTY_VALUE;
    end
  end

endmodule
